// File: rtl/reg_select_decoder_5_to_32_if.sv
// reg_select_decoder_5_to_32_if: request handshake, sweep control and register enables between control unit and decoder
interface reg_select_decoder_5_to_32_if;
  logic sel_valid, sel_ready, sel_dir, sweep_start, sweep_busy, sweep_done, err_range;
  logic [4:0] sel_index;
  logic [31:0] r_in, r_out;
  modport master(
    output sel_valid, sel_index, sel_dir, sweep_start,
    input sel_ready, sweep_busy, sweep_done, err_range, r_in, r_out
  );
  modport slave(
    input sel_valid, sel_index, sel_dir, sweep_start,
    output sel_ready, sweep_busy, sweep_done, err_range, r_in, r_out
  );
endinterface

// File: rtl/reg_select_decoder_5_to_32.sv
// reg_select_decoder_5_to_32: register index to registered one-hot Rin/Rout enables, with Rin sweep sequencer
module reg_select_decoder_5_to_32 #(
  parameter int NUM_REGS = 32,
  parameter int PULSE_CYCLES = 1
) (
  input logic clock,
  input logic clear,
  reg_select_decoder_5_to_32_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SWEEP, DONE} state_t;
  state_t state;
  logic [3:0] hold;
  logic [4:0] cnt;
  logic oor;
  logic [31:0] onehot;
  assign bus.sel_ready = state == IDLE && !bus.sweep_start && !clear;
  assign oor = 32'(bus.sel_index) >= NUM_REGS;
  assign onehot = 32'd1 << bus.sel_index;
  // control FSM; every output except sel_ready is a register, err/done default to single-cycle pulses
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      hold <= '0;
      cnt <= '0;
      bus.r_in <= '0;
      bus.r_out <= '0;
      bus.sweep_busy <= 1'b0;
      bus.sweep_done <= 1'b0;
      bus.err_range <= 1'b0;
    end else begin
      bus.err_range <= 1'b0;
      bus.sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sweep_start) begin
            state <= SWEEP;
            cnt <= '0;
            bus.r_in <= 32'd1;
            bus.sweep_busy <= 1'b1;
          end else if (bus.sel_valid) begin
            if (oor) begin
              bus.err_range <= 1'b1;
            end else begin
              state <= DRIVE;
              hold <= 4'd1;
              bus.r_in <= bus.sel_dir ? onehot : '0;
              bus.r_out <= bus.sel_dir ? '0 : onehot;
            end
          end
        end
        DRIVE: begin
          if (hold == 4'(PULSE_CYCLES)) begin
            state <= IDLE;
            hold <= '0;
            bus.r_in <= '0;
            bus.r_out <= '0;
          end else begin
            hold <= hold + 4'd1;
          end
        end
        SWEEP: begin
          if (cnt == 5'(NUM_REGS - 1)) begin
            state <= DONE;
            cnt <= '0;
            bus.r_in <= '0;
            bus.sweep_busy <= 1'b0;
            bus.sweep_done <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
            bus.r_in <= bus.r_in << 1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_select_decoder_5_to_32.sv
// tb_reg_select_decoder_5_to_32: scoreboard bench for two decoder configurations (32 regs/1 cycle, 16 regs/3 cycles)
module tb_reg_select_decoder_5_to_32;
  typedef struct packed {
    logic [31:0] ri;
    logic [31:0] ro;
    logic err;
    logic done;
    logic busy;
  } exp_t;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  always #5 clock = ~clock;
  reg_select_decoder_5_to_32_if a();
  reg_select_decoder_5_to_32_if b();
  reg_select_decoder_5_to_32 #(.NUM_REGS(32), .PULSE_CYCLES(1)) dut_a (.clock(clock), .clear(clear), .bus(a));
  reg_select_decoder_5_to_32 #(.NUM_REGS(16), .PULSE_CYCLES(3)) dut_b (.clock(clock), .clear(clear), .bus(b));
  task automatic chk(string nm, logic [71:0] got, logic [71:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic cmp(string nm, exp_t got, bit have, exp_t e);
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL %s unexpected output got=%h", nm, got);
    end else if (got !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, e);
    end
  endtask
  function automatic exp_t ex(logic [31:0] ri, logic [31:0] ro, logic err, logic done, logic busy);
    return {ri, ro, err, done, busy};
  endfunction
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  // monitor for configuration A: any active output pops one expected record
  always @(negedge clock) begin
    exp_t g;
    exp_t e;
    bit h;
    g = {a.r_in, a.r_out, a.err_range, a.sweep_done, a.sweep_busy};
    if ((|g) === 1'b1) begin
      h = qa.size() > 0;
      e = h ? qa.pop_front() : '0;
      cmp("mon_a", g, h, e);
    end
  end
  // monitor for configuration B
  always @(negedge clock) begin
    exp_t g;
    exp_t e;
    bit h;
    g = {b.r_in, b.r_out, b.err_range, b.sweep_done, b.sweep_busy};
    if ((|g) === 1'b1) begin
      h = qb.size() > 0;
      e = h ? qb.pop_front() : '0;
      cmp("mon_b", g, h, e);
    end
  end
  initial begin
    {a.sel_valid, a.sel_index, a.sel_dir, a.sweep_start} = '0;
    {b.sel_valid, b.sel_index, b.sel_dir, b.sweep_start} = '0;
    clear = 1'b1;
    step();
    step();
    chk("reset_a_outs", {a.r_in, a.r_out, a.err_range, a.sweep_done, a.sweep_busy}, '0);
    chk("reset_b_outs", {b.r_in, b.r_out, b.err_range, b.sweep_done, b.sweep_busy}, '0);
    chk("ready_in_clear", {71'd0, a.sel_ready}, 72'd0);
    clear = 1'b0;
    #1;
    chk("ready_after_clear", {71'd0, a.sel_ready}, 72'd1);
    // write enable for index 5, single cycle
    qa.push_back(ex(32'h0000_0020, '0, 0, 0, 0));
    a.sel_valid = 1'b1; a.sel_index = 5'd5; a.sel_dir = 1'b1;
    step();
    a.sel_valid = 1'b0;
    chk("t1_ready_low", {71'd0, a.sel_ready}, 72'd0);
    step();
    chk("t1_ready_back", {71'd0, a.sel_ready}, 72'd1);
    // drive enable for index 31
    qa.push_back(ex('0, 32'h8000_0000, 0, 0, 0));
    a.sel_valid = 1'b1; a.sel_index = 5'd31; a.sel_dir = 1'b0;
    step();
    a.sel_valid = 1'b0;
    step();
    // sweep with a simultaneous request: sweep wins, request dropped
    for (int n = 0; n < 32; n++) qa.push_back(ex(32'd1 << n, '0, 0, 0, 1));
    qa.push_back(ex('0, '0, 0, 1, 0));
    a.sweep_start = 1'b1; a.sel_valid = 1'b1; a.sel_index = 5'd3; a.sel_dir = 1'b0;
    #1;
    chk("sweep_prio_ready", {71'd0, a.sel_ready}, 72'd0);
    step();
    a.sweep_start = 1'b0; a.sel_valid = 1'b0;
    repeat (33) step();
    chk("post_sweep_ready", {71'd0, a.sel_ready}, 72'd1);
    // clear in the middle of a sweep at step 10
    for (int n = 0; n <= 10; n++) qa.push_back(ex(32'd1 << n, '0, 0, 0, 1));
    a.sweep_start = 1'b1;
    step();
    a.sweep_start = 1'b0;
    repeat (10) step();
    clear = 1'b1;
    step();
    chk("clear_mid_sweep", {a.r_in, a.r_out, a.err_range, a.sweep_done, a.sweep_busy}, '0);
    clear = 1'b0;
    #1;
    chk("clear_ready", {71'd0, a.sel_ready}, 72'd1);
    repeat (3) step();
    // config B: 3-cycle pulse, valid held, re-accept after one idle cycle
    repeat (3) qb.push_back(ex(32'd1, '0, 0, 0, 0));
    b.sel_valid = 1'b1; b.sel_index = 5'd0; b.sel_dir = 1'b1;
    step();
    chk("b_ready_low", {71'd0, b.sel_ready}, 72'd0);
    step();
    step();
    step();
    chk("b_ready_reaccept", {71'd0, b.sel_ready}, 72'd1);
    repeat (3) qb.push_back(ex(32'd1, '0, 0, 0, 0));
    step();
    b.sel_valid = 1'b0; b.sel_index = 5'd9; b.sel_dir = 1'b0;
    step();
    step();
    step();
    chk("b_idle_after", {71'd0, b.sel_ready}, 72'd1);
    // out-of-range index raises err only, ready stays high
    qb.push_back(ex('0, '0, 1, 0, 0));
    b.sel_valid = 1'b1; b.sel_index = 5'd20; b.sel_dir = 1'b1;
    step();
    b.sel_valid = 1'b0;
    chk("b_err_ready", {71'd0, b.sel_ready}, 72'd1);
    step();
    // top in-range index 15, drive direction
    repeat (3) qb.push_back(ex('0, 32'h0000_8000, 0, 0, 0));
    b.sel_valid = 1'b1; b.sel_index = 5'd15; b.sel_dir = 1'b0;
    step();
    b.sel_valid = 1'b0;
    repeat (3) step();
    // 16-register sweep
    for (int n = 0; n < 16; n++) qb.push_back(ex(32'd1 << n, '0, 0, 0, 1));
    qb.push_back(ex('0, '0, 0, 1, 0));
    b.sweep_start = 1'b1;
    step();
    b.sweep_start = 1'b0;
    repeat (20) step();
    chk("qa_drained", 72'(qa.size()), 72'd0);
    chk("qb_drained", 72'(qb.size()), 72'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
